// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the three-port SDRAM arbiter.
// Holds the port count, address/data widths, the transaction FSM state
// type and a small helper used by the priority selector.
package sdram_arb_pkg;

    localparam int NPORTS = 3;
    localparam int ADDR_W = 25;
    localparam int DATA_W = 8;
    localparam int IDX_W  = $clog2(NPORTS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STROBE,
        ST_ARM,
        ST_WAIT,
        ST_DONE
    } arb_state_e;

    // Next port index with wrap-around, used to walk the ports in
    // round-robin order starting just after the previous winner.
    function automatic logic [IDX_W-1:0] wrapInc(input logic [IDX_W-1:0] idx);
        if (idx == IDX_W'(NPORTS - 1)) begin
            return '0;
        end
        return idx + IDX_W'(1);
    endfunction

endpackage

// File: rtl/sdram_arb_rr.sv
// Combinational request selector for the SDRAM arbiter.
// Ports:
//   req_i   - one request bit per port
//   last_i  - index of the previous winner
//   grant_o - index of the selected port
//   valid_o - high when any request is pending
// With RR_EN = 1 the search begins one past the previous winner; with
// RR_EN = 0 it always begins at port 0, giving port 0 the top priority.
module sdram_arb_rr
    import sdram_arb_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic [NPORTS-1:0] req_i,
    input  logic [IDX_W-1:0]  last_i,
    output logic [IDX_W-1:0]  grant_o,
    output logic              valid_o
);

    logic [IDX_W-1:0] cand;

    // Walk every port once from the starting candidate and keep the first
    // one that is requesting.
    always_comb begin
        grant_o = '0;
        valid_o = 1'b0;
        cand    = RR_EN ? wrapInc(last_i) : '0;
        for (int k = 0; k < NPORTS; k++) begin
            if (!valid_o && req_i[cand]) begin
                grant_o = cand;
                valid_o = 1'b1;
            end
            cand = wrapInc(cand);
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Three-port arbiter in front of a single-transaction SDRAM controller.
// Ports:
//   clk, reset             - system clock, asynchronous active-high reset
//   reqN/weN/addrN/dinN    - per-port request, direction, address, write data
//   ackN/doutN             - per-port completion pulse and read data
//   mem_addr/mem_din       - address and write data toward the controller
//   mem_we/mem_rd          - write/read strobes (controller acts on rising edge)
//   mem_dout/mem_ready     - read data and ready/data-valid from the controller
//   busy                   - high whenever a transaction is in progress
// One transaction at a time: grant in IDLE, raise the strobe, ignore the
// stale ready for ARM_CYCLES, wait for ready, then ack in DONE.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ARM_CYCLES = 2,
    parameter bit RR_EN      = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] din0,
    output logic              ack0,
    output logic [DATA_W-1:0] dout0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] din1,
    output logic              ack1,
    output logic [DATA_W-1:0] dout1,
    input  logic              req2,
    input  logic              we2,
    input  logic [ADDR_W-1:0] addr2,
    input  logic [DATA_W-1:0] din2,
    output logic              ack2,
    output logic [DATA_W-1:0] dout2,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_we,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_dout,
    input  logic              mem_ready,
    output logic              busy
);

    localparam int CNT_W = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  winner_q, winner_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              we_q, we_d;
    logic [CNT_W-1:0]  armCnt_q, armCnt_d;
    logic [DATA_W-1:0] dout_q [NPORTS];
    logic [DATA_W-1:0] dout_d [NPORTS];

    logic [NPORTS-1:0] reqVec;
    logic              weArr   [NPORTS];
    logic [ADDR_W-1:0] addrArr [NPORTS];
    logic [DATA_W-1:0] dinArr  [NPORTS];
    logic [NPORTS-1:0] ackVec;
    logic [IDX_W-1:0]  grantIdx;
    logic              grantValid;
    logic              strobeOn;

    assign reqVec     = {req2, req1, req0};
    assign weArr[0]   = we0;
    assign weArr[1]   = we1;
    assign weArr[2]   = we2;
    assign addrArr[0] = addr0;
    assign addrArr[1] = addr1;
    assign addrArr[2] = addr2;
    assign dinArr[0]  = din0;
    assign dinArr[1]  = din1;
    assign dinArr[2]  = din2;

    sdram_arb_rr #(
        .RR_EN (RR_EN)
    ) u_rr (
        .req_i   (reqVec),
        .last_i  (last_q),
        .grant_o (grantIdx),
        .valid_o (grantValid)
    );

    // Transaction FSM next state plus the per-transaction registers. The
    // winner's address, data and direction are latched on the grant edge so
    // the controller-facing outputs never follow the live request inputs.
    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        last_d   = last_q;
        addr_d   = addr_q;
        din_d    = din_q;
        we_d     = we_q;
        armCnt_d = armCnt_q;
        dout_d   = dout_q;
        case (state_q)
            ST_IDLE: begin
                // A low ready here means controller init or refresh; hold off.
                if (mem_ready && grantValid) begin
                    state_d  = ST_STROBE;
                    winner_d = grantIdx;
                    last_d   = grantIdx;
                    addr_d   = addrArr[grantIdx];
                    din_d    = dinArr[grantIdx];
                    we_d     = weArr[grantIdx];
                end
            end
            ST_STROBE: begin
                state_d  = ST_ARM;
                armCnt_d = '0;
            end
            ST_ARM: begin
                // Ready may still be high from the previous access; ignore it
                // until the controller has had time to react to the strobe.
                if (armCnt_q == CNT_W'(ARM_CYCLES - 1)) begin
                    state_d = ST_WAIT;
                end else begin
                    armCnt_d = armCnt_q + CNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (mem_ready) begin
                    state_d = ST_DONE;
                    if (!we_q) begin
                        dout_d[winner_q] = mem_dout;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and data registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            winner_q <= '0;
            last_q   <= IDX_W'(NPORTS - 1);
            addr_q   <= '0;
            din_q    <= '0;
            we_q     <= 1'b0;
            armCnt_q <= '0;
            for (int n = 0; n < NPORTS; n++) begin
                dout_q[n] <= '0;
            end
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            last_q   <= last_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            we_q     <= we_d;
            armCnt_q <= armCnt_d;
            dout_q   <= dout_d;
        end
    end

    // Strobes are decoded from registered state only, so both drop the
    // instant reset asserts and stay low through DONE and IDLE.
    always_comb begin
        strobeOn = (state_q == ST_STROBE) || (state_q == ST_ARM) || (state_q == ST_WAIT);
        ackVec   = '0;
        if (state_q == ST_DONE) begin
            ackVec[winner_q] = 1'b1;
        end
    end

    assign mem_we   = strobeOn && we_q;
    assign mem_rd   = strobeOn && !we_q;
    assign mem_addr = addr_q;
    assign mem_din  = din_q;
    assign busy     = (state_q != ST_IDLE);
    assign ack0     = ackVec[0];
    assign ack1     = ackVec[1];
    assign ack2     = ackVec[2];
    assign dout0    = dout_q[0];
    assign dout1    = dout_q[1];
    assign dout2    = dout_q[2];

endmodule

// File: tb/tb_sdram_arbiter.sv
module tb_sdram_arbiter;

    localparam int READ_LAT  = 6;
    localparam int WRITE_LAT = 4;

    typedef struct {
        bit          we;
        logic [24:0] addr;
        logic [7:0]  din;
    } txn_t;

    typedef struct {
        int         port;
        bit         isRead;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        int          port;
        bit          we;
        logic [24:0] addr;
        logic [7:0]  din;
        logic [7:0]  expData;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   nAssert = 0;
    int   nFail = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Instance A: round-robin, driven by the controller model below
    logic [2:0]  reqA = 3'b000;
    logic [2:0]  weA = 3'b000;
    logic [24:0] addrA [3];
    logic [7:0]  dinA [3];
    wire  [2:0]  ackA;
    wire  [7:0]  doutA [3];
    wire  [24:0] memAddrA;
    wire  [7:0]  memDinA;
    wire         memWeA;
    wire         memRdA;
    wire         busyA;
    wire         memReadyA;
    logic [7:0]  mDout;

    sdram_arbiter #(.ARM_CYCLES(2), .RR_EN(1'b1)) dutA (
        .clk(clk), .reset(reset),
        .req0(reqA[0]), .we0(weA[0]), .addr0(addrA[0]), .din0(dinA[0]), .ack0(ackA[0]), .dout0(doutA[0]),
        .req1(reqA[1]), .we1(weA[1]), .addr1(addrA[1]), .din1(dinA[1]), .ack1(ackA[1]), .dout1(doutA[1]),
        .req2(reqA[2]), .we2(weA[2]), .addr2(addrA[2]), .din2(dinA[2]), .ack2(ackA[2]), .dout2(doutA[2]),
        .mem_addr(memAddrA), .mem_din(memDinA), .mem_we(memWeA), .mem_rd(memRdA),
        .mem_dout(mDout), .mem_ready(memReadyA), .busy(busyA)
    );

    // Instance B: fixed priority, controller always ready
    logic [2:0]  reqB = 3'b000;
    logic [2:0]  weB = 3'b111;
    logic [24:0] addrB = 25'h0;
    logic [7:0]  dinB = 8'h00;
    logic        memReadyB = 1'b1;
    logic [7:0]  memDoutB = 8'h00;
    wire  [2:0]  ackB;
    wire  [7:0]  doutB [3];
    wire  [24:0] memAddrB;
    wire  [7:0]  memDinB;
    wire         memWeB;
    wire         memRdB;
    wire         busyB;

    sdram_arbiter #(.ARM_CYCLES(2), .RR_EN(1'b0)) dutB (
        .clk(clk), .reset(reset),
        .req0(reqB[0]), .we0(weB[0]), .addr0(addrB), .din0(dinB), .ack0(ackB[0]), .dout0(doutB[0]),
        .req1(reqB[1]), .we1(weB[1]), .addr1(addrB), .din1(dinB), .ack1(ackB[1]), .dout1(doutB[1]),
        .req2(reqB[2]), .we2(weB[2]), .addr2(addrB), .din2(dinB), .ack2(ackB[2]), .dout2(doutB[2]),
        .mem_addr(memAddrB), .mem_din(memDinB), .mem_we(memWeB), .mem_rd(memRdB),
        .mem_dout(memDoutB), .mem_ready(memReadyB), .busy(busyB)
    );

    // Unwritten memory bytes read back as a fixed function of the address
    function automatic logic [7:0] initByte(input logic [24:0] a);
        return a[7:0] ^ 8'hA5;
    endfunction

    logic [7:0]  memArr [4096];
    logic        written [4096];
    logic        mRdy;
    logic        mHold = 1'b0;
    int          mCnt;
    logic        prevStrobe;
    logic        cacheValid;
    logic [23:0] cacheWord;
    logic        pendRead;
    logic [24:0] pendAddr;
    int          strobeEdgesA;

    function automatic logic [7:0] readMem(input logic [24:0] a);
        if (written[a[11:0]] === 1'b1) return memArr[a[11:0]];
        return initByte(a);
    endfunction

    assign memReadyA = mRdy & ~mHold;

    // Controller model: ready drops the cycle after a strobe rise and comes
    // back after the access latency; a read of the word last read stays ready.
    always @(posedge clk) begin
        if (reset) begin
            mRdy <= 1'b1;
            mCnt <= 0;
            prevStrobe <= 1'b0;
            cacheValid <= 1'b0;
            cacheWord <= '0;
            pendRead <= 1'b0;
            pendAddr <= '0;
            mDout <= '0;
            strobeEdgesA <= 0;
        end else begin
            prevStrobe <= memWeA | memRdA;
            if ((memWeA | memRdA) && !prevStrobe) begin
                strobeEdgesA <= strobeEdgesA + 1;
                if (memWeA) begin
                    memArr[memAddrA[11:0]] <= memDinA;
                    written[memAddrA[11:0]] <= 1'b1;
                    cacheValid <= 1'b0;
                    pendRead <= 1'b0;
                    mRdy <= 1'b0;
                    mCnt <= WRITE_LAT;
                end else if (cacheValid && cacheWord == memAddrA[24:1]) begin
                    mDout <= readMem(memAddrA);
                end else begin
                    mRdy <= 1'b0;
                    mCnt <= READ_LAT;
                    pendRead <= 1'b1;
                    pendAddr <= memAddrA;
                    cacheValid <= 1'b1;
                    cacheWord <= memAddrA[24:1];
                end
            end else if (mCnt > 0) begin
                mCnt <= mCnt - 1;
                if (mCnt == 1) begin
                    mRdy <= 1'b1;
                    if (pendRead) mDout <= readMem(pendAddr);
                end
            end
        end
    end

    txn_t pendQ [3][$];
    exp_t sbA [$];
    int   sbB [$];
    int   ackCntA [3] = '{0, 0, 0};
    int   grantCycA = 0;
    int   lastLatA = 0;
    bit   prevBusyA = 1'b0;
    bit   busySeenA = 1'b0;
    logic [2:0] ackPrevA = 3'b000;
    int   holdB0 = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nAssert++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int port, input bit isWrite, input logic [24:0] a,
                                 input logic [7:0] d, input logic [7:0] expData);
        txn_t t;
        exp_t e;
        t.we = isWrite;
        t.addr = a;
        t.din = d;
        e.port = port;
        e.isRead = !isWrite;
        e.data = expData;
        pendQ[port].push_back(t);
        sbA.push_back(e);
    endtask

    function automatic bit allIdleA();
        return sbA.size() == 0 && pendQ[0].size() == 0 && pendQ[1].size() == 0 &&
               pendQ[2].size() == 0 && !busyA;
    endfunction

    task automatic waitDrainA(input int budget, input string name);
        bit done;
        done = 1'b0;
        for (int k = 0; k < budget && !done; k++) begin
            @(negedge clk);
            #1;
            if (allIdleA()) done = 1'b1;
        end
        nAssert++;
        if (!done) begin
            nFail++;
            $display("[TB] FAIL %s: still busy after %0d cycles, expected idle (%0d acks outstanding)",
                     name, budget, sbA.size());
        end
        @(posedge clk);
        #2;
    endtask

    // Requesters and ack checking for both instances, sampled mid-cycle
    initial begin
        txn_t tmp;
        exp_t e;
        int   gotB;
        forever begin
            @(negedge clk);
            if (busyA && !prevBusyA) grantCycA = cyc;
            prevBusyA = busyA;
            if (busyA) busySeenA = 1'b1;
            if (ackA != 3'b000) begin
                checkOutput("ack_onehot", 32'($countones(ackA)), 32'd1);
                checkOutput("ack_width", 32'(ackA & ackPrevA), 32'd0);
                for (int n = 0; n < 3; n++) begin
                    if (ackA[n]) begin
                        ackCntA[n]++;
                        lastLatA = cyc - grantCycA + 1;
                        nAssert++;
                        if (sbA.size() == 0) begin
                            nFail++;
                            $display("[TB] FAIL ack%0d_unexpected: got ack%0d, expected no ack", n, n);
                        end else begin
                            e = sbA.pop_front();
                            if (e.port != n || (e.isRead && doutA[n] !== e.data)) begin
                                nFail++;
                                $display("[TB] FAIL ack%0d_order_data: got port %0d dout %02h, expected port %0d dout %02h",
                                         n, n, doutA[n], e.port, e.isRead ? e.data : doutA[n]);
                            end
                        end
                        if (pendQ[n].size() > 0) tmp = pendQ[n].pop_front();
                    end
                end
            end
            ackPrevA = ackA;
            for (int n = 0; n < 3; n++) begin
                reqA[n] = pendQ[n].size() != 0;
                if (pendQ[n].size() != 0) begin
                    weA[n] = pendQ[n][0].we;
                    addrA[n] = pendQ[n][0].addr;
                    dinA[n] = pendQ[n][0].din;
                end
            end
            for (int n = 0; n < 3; n++) begin
                if (ackB[n]) begin
                    nAssert++;
                    gotB = (sbB.size() == 0) ? -1 : sbB.pop_front();
                    if (gotB != n) begin
                        nFail++;
                        $display("[TB] FAIL fixed_prio_order: got ack port %0d, expected port %0d", n, gotB);
                    end
                    if (n == 0) begin
                        holdB0--;
                        if (holdB0 <= 0) reqB[0] = 1'b0;
                    end else begin
                        reqB[n] = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs [8];
        int   edgesBefore;
        int   ackBefore;
        bit   doneB;

        for (int n = 0; n < 3; n++) begin
            addrA[n] = '0;
            dinA[n] = '0;
        end

        vecs[0] = '{1, 1'b1, 25'h0001234, 8'h5A, 8'h00};
        vecs[1] = '{1, 1'b0, 25'h0001234, 8'h00, 8'h5A};
        vecs[2] = '{0, 1'b1, 25'h1FFFFFF, 8'hC3, 8'h00};
        vecs[3] = '{2, 1'b0, 25'h1FFFFFF, 8'h00, 8'hC3};
        vecs[4] = '{0, 1'b0, 25'h0000000, 8'h00, initByte(25'h0000000)};
        vecs[5] = '{2, 1'b1, 25'h0000ABC, 8'h00, 8'h00};
        vecs[6] = '{0, 1'b0, 25'h0000ABC, 8'h00, 8'h00};
        vecs[7] = '{1, 1'b0, 25'h0000ABD, 8'h00, initByte(25'h0000ABD)};

        // Reset values while reset is held
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_mem_rd", 32'(memRdA), 32'd0);
        checkOutput("rst_mem_we", 32'(memWeA), 32'd0);
        checkOutput("rst_ack", 32'(ackA), 32'd0);
        checkOutput("rst_busy", 32'(busyA), 32'd0);
        checkOutput("rst_mem_addr", 32'(memAddrA), 32'd0);
        checkOutput("rst_mem_din", 32'(memDinA), 32'd0);
        checkOutput("rst_dout0", 32'(doutA[0]), 32'd0);
        checkOutput("rst_dout1", 32'(doutA[1]), 32'd0);
        checkOutput("rst_dout2", 32'(doutA[2]), 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #2;

        // Three simultaneous requesters, port 0 holding a second request
        applyStimulus(0, 1'b0, 25'h0000211, 8'h00, initByte(25'h0000211));
        applyStimulus(1, 1'b0, 25'h0000322, 8'h00, initByte(25'h0000322));
        applyStimulus(2, 1'b0, 25'h0000433, 8'h00, initByte(25'h0000433));
        applyStimulus(0, 1'b0, 25'h0000244, 8'h00, initByte(25'h0000244));
        waitDrainA(200, "rr_three_ports");

        // Table of single transactions
        edgesBefore = strobeEdgesA;
        ackBefore = ackCntA[1];
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].din, vecs[i].expData);
            waitDrainA(100, "vector");
            if (i == 1) begin
                checkOutput("wr_rd_strobe_edges", 32'(strobeEdgesA - edgesBefore), 32'd2);
                checkOutput("wr_rd_ack1_count", 32'(ackCntA[1] - ackBefore), 32'd2);
                checkOutput("wr_rd_dout1", 32'(doutA[1]), 32'h5A);
            end
        end
        checkOutput("dout2_held_over_write", 32'(doutA[2]), 32'hC3);

        // Miss read then a same-word read that stays ready
        applyStimulus(0, 1'b0, 25'h0000100, 8'h00, initByte(25'h0000100));
        waitDrainA(100, "miss_read");
        checkOutput("miss_read_latency", 32'(lastLatA), 32'd9);
        applyStimulus(0, 1'b0, 25'h0000101, 8'h00, initByte(25'h0000101));
        waitDrainA(100, "cached_read");
        checkOutput("cached_read_latency", 32'(lastLatA), 32'd5);
        checkOutput("cached_read_dout0", 32'(doutA[0]), 32'hA4);

        // Controller not ready for a long stretch with port 2 waiting
        mHold = 1'b1;
        edgesBefore = strobeEdgesA;
        busySeenA = 1'b0;
        applyStimulus(2, 1'b0, 25'h0000600, 8'h00, initByte(25'h0000600));
        repeat (500) @(posedge clk);
        #2;
        checkOutput("hold_no_strobe", 32'(strobeEdgesA - edgesBefore), 32'd0);
        checkOutput("hold_no_grant", 32'(busySeenA), 32'd0);
        mHold = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("grant_after_ready", 32'(busyA), 32'd1);
        waitDrainA(100, "after_hold");

        // Reset in the middle of a port 0 read
        pendQ[0].push_back('{1'b0, 25'h0000800, 8'h00});
        doneB = 1'b0;
        for (int k = 0; k < 50 && !doneB; k++) begin
            @(negedge clk);
            #1;
            if (busyA) doneB = 1'b1;
        end
        checkOutput("abort_grant_seen", 32'(doneB), 32'd1);
        repeat (3) @(posedge clk);
        #2;
        checkOutput("abort_in_wait_rd", 32'(memRdA), 32'd1);
        ackBefore = ackCntA[0];
        reset = 1'b1;
        pendQ[0].delete();
        #1;
        checkOutput("abort_rd_low", 32'(memRdA), 32'd0);
        checkOutput("abort_we_low", 32'(memWeA), 32'd0);
        checkOutput("abort_busy_low", 32'(busyA), 32'd0);
        checkOutput("abort_dout0", 32'(doutA[0]), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        checkOutput("abort_no_ack0", 32'(ackCntA[0] - ackBefore), 32'd0);
        applyStimulus(0, 1'b0, 25'h0000810, 8'h00, initByte(25'h0000810));
        waitDrainA(100, "after_abort");

        // Fixed priority: port 0 held for three transactions
        holdB0 = 3;
        sbB.push_back(0);
        sbB.push_back(0);
        sbB.push_back(0);
        sbB.push_back(1);
        sbB.push_back(2);
        reqB = 3'b111;
        doneB = 1'b0;
        for (int k = 0; k < 200 && !doneB; k++) begin
            @(negedge clk);
            #1;
            if (sbB.size() == 0 && reqB == 3'b000 && !busyB) doneB = 1'b1;
        end
        checkOutput("fixed_prio_drained", 32'(doneB), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter ARM_CYCLES, default 2, cycles after strobe rise before mem_ready is sampled.
REQ-002 SHALL have parameter RR_EN, default 1; 1 = round-robin, 0 = fixed priority (port 0 highest).
REQ-003 clk  in  1  system clock, same clock as the SDRAM controller.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 reqN  in  1  request from port N (N = 0..2); held high until ackN.
REQ-006 weN  in  1  port N write (1) / read (0); stable while reqN.
REQ-007 addrN  in  25  port N byte address; stable while reqN.
REQ-008 dinN  in  8  port N write data; stable while reqN.
REQ-009 ackN  out  1  one-cycle pulse: port N transaction complete.
REQ-010 doutN  out  8  port N read data; valid with ackN, held until the next read ack on port N.
REQ-011 mem_addr  out  25  controller address.
REQ-012 mem_din  out  8  controller write data.
REQ-013 mem_we  out  1  controller write strobe; the controller acts on its rising edge.
REQ-014 mem_rd  out  1  controller read strobe; the controller acts on its rising edge.
REQ-015 mem_dout  in  8  controller read data.
REQ-016 mem_ready  in  1  controller ready / data valid.
REQ-017 busy  out  1  high in every state except IDLE.

Function
REQ-018 States: IDLE, STROBE, ARM, WAIT, DONE.
- IDLE -> STROBE when mem_ready = 1 and any reqN = 1.
- STROBE -> ARM after one cycle.
- ARM -> WAIT after ARM_CYCLES cycles.
- WAIT -> DONE when mem_ready = 1.
- DONE -> IDLE after one cycle.
REQ-019 Grant is taken in IDLE. The winner index, addr, din and we are registered on the same edge as IDLE -> STROBE. mem_addr, mem_din and mem_we/mem_rd select are driven from these registers only.
REQ-020 mem_rd (read) or mem_we (write) SHALL be high from STROBE through WAIT and low in DONE and IDLE. Only one strobe is high at any time.
REQ-021 Because both strobes are low for at least DONE + IDLE (2 cycles), every transaction presents a fresh rising edge to the controller.
REQ-022 ARM masks the stale mem_ready = 1 left over from the previous access. A same-word cached read, where mem_ready never drops, completes at the end of ARM.
REQ-023 On the WAIT -> DONE edge: if read, doutN <= mem_dout; ackN pulses during DONE.
REQ-024 Latency with mem_ready already high (cached read or write-ready) SHALL be 3 + ARM_CYCLES cycles from the grant edge to ackN.
REQ-025 Round-robin (RR_EN = 1):
- search starts at (last winner + 1) mod 3;
- last winner updates on each grant;
- last winner resets to 2, so port 0 wins first.
REQ-026 Simultaneous requests: exactly one grant per IDLE. Losers keep reqN high and are served in later rounds. No port waits more than 2 foreign transactions when RR_EN = 1.
REQ-027 If reqN drops before ackN, the transaction in flight still completes and ackN still pulses. Requesters SHALL NOT do this.
REQ-028 If reqN is still high in the cycle after ackN, it is a new request and is eligible at the next IDLE.
REQ-029 While mem_ready = 0 in IDLE (controller init or a refresh tail), no grant is issued and requests wait.
REQ-030 Every ackN SHALL be exactly one cycle wide; at most one ackN is high per cycle.

Reset
REQ-031 Reset SHALL immediately force:
- state = IDLE;
- mem_rd = mem_we = 0;
- all ackN = 0; busy = 0;
- doutN = 0; mem_addr = 0; mem_din = 0;
- last winner = 2.
REQ-032 Reset mid-transaction abandons it: no ack is issued, and the first grant after reset waits for mem_ready = 1.

Structure
REQ-033 Package sdram_arb_pkg SHALL hold:
- the state enum;
- NPORTS = 3;
- the address width (25) and data width (8).
REQ-034 The round-robin/fixed priority selector SHALL be the sub-module sdram_arb_rr: combinational, 3-bit request vector in, last winner in, 2-bit index plus valid out.
REQ-035 Implementation SHALL use per-port arrays indexed by the registered winner, so port count changes only the package.

Verification
REQ-036 Bench SHALL model the controller: ready drops 1 cycle after a strobe edge; read latency 6 cycles; same-word reads keep ready high.
REQ-037 Port 1 writes 0x5A at 0x0001234 then reads it back -> ack1 pulses twice, dout1 = 0x5A, exactly two mem_we/mem_rd rising edges seen.
REQ-038 req0, req1 and req2 all raised in the same cycle, RR_EN = 1 -> grant order 0,1,2, then 0 again if req0 is still held.
REQ-039 Repeat REQ-038 with RR_EN = 0 and req0 held continuously -> port 0 always wins; ports 1 and 2 wait until req0 drops.
REQ-040 Two reads to 0x100 then 0x101 (mem_ready stays high) -> second ack arrives 5 cycles after grant; dout = model byte for 0x101.
REQ-041 mem_ready held 0 for 500 cycles with req2 pending -> no strobe edge; grant follows within 1 cycle of mem_ready rising.
REQ-042 Reset asserted during WAIT of a port 0 read -> strobes low immediately, no ack0; next request completes normally.
